// File: rtl/hulohot_seq_alu_pkg.sv
// hulohot_alu_pkg: opcode encodings and handshake FSM states shared by the ALU files
package hulohot_alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/hulohot_seq_alu_if.sv
// hulohot_seq_alu_if: command (in_valid/in_ready/a/b/opcode) and result (out_valid/out_ready/z/zero/err) handshakes; master drives commands, slave is the ALU
interface hulohot_seq_alu_if #(parameter int WIDTH = 3);
  localparam int ZW = 2 * WIDTH;
  logic in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [WIDTH-1:0] a, b;
  logic [2:0] opcode;
  logic [ZW-1:0] z;
  modport master(output in_valid, a, b, opcode, out_ready, input in_ready, out_valid, z, zero, err);
  modport slave(input in_valid, a, b, opcode, out_ready, output in_ready, out_valid, z, zero, err);
endinterface

// File: rtl/hulohot_seq_alu_mul.sv
// hulohot_alu_mul_seq: shift-add multiplier (clk, rst, start loads a/b, done high when p holds the 2*WIDTH-bit product after WIDTH steps)
module hulohot_alu_mul_seq #(parameter int WIDTH = 3) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      p <= '0;
    end else if (start) begin
      p <= '0;
      mc <= (2*WIDTH)'(a);
      mp <= b;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      p <= mp[0] ? p + mc : p;
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt - 1'b1;
    end
  end
  assign done = cnt == '0;
endmodule

// File: rtl/hulohot_seq_alu.sv
// hulohot_seq_alu: registered valid/ready ALU (clk, rst, bus slave: a/b/opcode in, z/zero/err out); define ALU_MUL_EN for the iterative MUL, otherwise opcode 111 reports err
module hulohot_seq_alu
  import hulohot_alu_pkg::*;
#(parameter int WIDTH = 3) (
  input logic clk,
  input logic rst,
  hulohot_seq_alu_if.slave bus
);
  localparam int ZW = 2 * WIDTH;
  state_t state;
  logic [WIDTH-1:0] ra, rb, shl;
  logic [2:0] rop;
  logic [ZW-1:0] res, prod;
  logic bad, mul_done;
`ifdef ALU_MUL_EN
  localparam logic mul_en = 1'b1;
  hulohot_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(state == S_IDLE && bus.in_valid && bus.opcode == OP_MUL),
    .a(bus.a),
    .b(bus.b),
    .done(mul_done),
    .p(prod)
  );
`else
  localparam logic mul_en = 1'b0;
  assign mul_done = 1'b0;
  assign prod = '0;
`endif
  always_comb begin
    res = '0;
    bad = 1'b0;
    shl = ra << rb;
    case (rop)
      OP_ADD: res = ZW'(ra) + ZW'(rb);
      OP_SUB: res = ZW'({ra < rb, ra - rb});
      OP_AND: res = ZW'(ra & rb);
      OP_OR:  res = ZW'(ra | rb);
      OP_XOR: res = ZW'(ra ^ rb);
      OP_SHL: res = ZW'(shl);
      OP_SHR: res = ZW'(ra >> rb);
      default: bad = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.z <= '0;
      bus.zero <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          ra <= bus.a;
          rb <= bus.b;
          rop <= bus.opcode;
          bus.in_ready <= 1'b0;
          state <= (mul_en && bus.opcode == OP_MUL) ? S_MUL : S_DONE;
        end
        S_MUL: if (mul_done) begin
          state <= S_DONE;
          bus.out_valid <= 1'b1;
          bus.z <= prod;
          bus.zero <= prod == '0;
          bus.err <= 1'b0;
        end
        S_DONE: if (!bus.out_valid) begin
          bus.out_valid <= 1'b1;
          bus.z <= res;
          bus.zero <= res == '0;
          bus.err <= bad;
        end else if (bus.out_ready) begin
          state <= S_IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hulohot_seq_alu.sv
// tb_hulohot_seq_alu: directed and random transactions on WIDTH=3 and WIDTH=8 ALUs checked against an arithmetic reference model
module tb_hulohot_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hulohot_seq_alu_if #(.WIDTH(3)) i3();
  hulohot_seq_alu_if #(.WIDTH(8)) i8();
  hulohot_seq_alu #(.WIDTH(3)) dut3(.clk(clk), .rst(rst), .bus(i3.slave));
  hulohot_seq_alu #(.WIDTH(8)) dut8(.clk(clk), .rst(rst), .bus(i8.slave));
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic longint unsigned model(input int w, input int a, input int b, input int op, output bit e);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    e = (op == 7) && !MUL_EN;
    case (op)
      0: return a + b;
      1: return ((a - b) & m) | ((a < b) ? m + 1 : 0);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (b >= w) ? 0 : (longint'(a) << b) & m;
      6: return (b >= w) ? 0 : a >> b;
      default: return MUL_EN ? longint'(a) * longint'(b) : 0;
    endcase
  endfunction
  task automatic xact3(input int a, input int b, input int op, input int hold);
    longint unsigned ez;
    bit ee;
    int lat;
    logic [5:0] z0;
    ez = model(3, a, b, op, ee);
    chk("w3_in_ready_idle", i3.in_ready, 1);
    i3.in_valid = 1'b1;
    i3.a = 3'(a);
    i3.b = 3'(b);
    i3.opcode = 3'(op);
    @(posedge clk); #1;
    i3.in_valid = 1'b0;
    i3.a = 3'($urandom);
    i3.b = 3'($urandom);
    i3.opcode = 3'($urandom);
    lat = 0;
    while (!i3.out_valid && lat < 40) begin
      chk("w3_in_ready_busy", i3.in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("w3_latency", lat, (op == 7 && MUL_EN) ? 4 : 1);
    chk("w3_z", i3.z, ez);
    chk("w3_zero", i3.zero, ez == 0);
    chk("w3_err", i3.err, ee);
    z0 = i3.z;
    repeat (hold) begin
      i3.in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("w3_hold_valid", i3.out_valid, 1);
      chk("w3_hold_z", i3.z, z0);
      chk("w3_hold_flags", {i3.zero, i3.err}, {ez == 0, ee});
      chk("w3_hold_in_ready", i3.in_ready, 0);
    end
    i3.in_valid = 1'b0;
    i3.out_ready = 1'b1;
    @(posedge clk); #1;
    i3.out_ready = 1'b0;
    chk("w3_release_valid", i3.out_valid, 0);
    chk("w3_release_in_ready", i3.in_ready, 1);
  endtask
  task automatic xact8(input int a, input int b, input int op);
    longint unsigned ez;
    bit ee;
    int lat;
    ez = model(8, a, b, op, ee);
    i8.in_valid = 1'b1;
    i8.a = 8'(a);
    i8.b = 8'(b);
    i8.opcode = 3'(op);
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", lat, (op == 7 && MUL_EN) ? 9 : 1);
    chk("w8_z", i8.z, ez);
    chk("w8_flags", {i8.zero, i8.err}, {ez == 0, ee});
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0;
    chk("w8_release", {i8.out_valid, i8.in_ready}, 2'b01);
  endtask
  initial begin
    {i3.in_valid, i3.out_ready, i3.a, i3.b, i3.opcode} = '0;
    {i8.in_valid, i8.out_ready, i8.a, i8.b, i8.opcode} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", i3.in_ready, 1);
    chk("rst_out_valid", i3.out_valid, 0);
    chk("rst_z", i3.z, 0);
    chk("rst_zero", i3.zero, 0);
    chk("rst_err", i3.err, 0);
    chk("rst_w8", {i8.in_ready, i8.out_valid, i8.z}, {1'b1, 1'b0, 16'd0});
    rst = 1'b0;
    xact3(7, 7, 0, 0);
    xact3(2, 5, 1, 0);
    xact3(6, 3, 2, 0);
    xact3(4, 1, 3, 0);
    xact3(5, 5, 4, 0);
    xact3(3, 1, 5, 0);
    xact3(3, 3, 5, 0);
    xact3(6, 2, 6, 0);
    xact3(7, 6, 7, 0);
    xact3(5, 3, 0, 5);
    xact3(7, 6, 7, 5);
    i3.in_valid = 1'b1;
    i3.a = 3'd7;
    i3.b = 3'd6;
    i3.opcode = 3'd7;
    @(posedge clk); #1;
    i3.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", i3.out_valid, 0);
    chk("abort_z", i3.z, 0);
    chk("abort_in_ready", i3.in_ready, 1);
    xact3(1, 1, 0, 0);
    repeat (60) begin
      xact3($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    xact8(255, 255, 0);
    xact8(200, 100, 1);
    xact8(255, 255, 7);
    repeat (20) xact8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
    repeat (10) xact8($urandom_range(0, 255), $urandom_range(0, 10), $urandom_range(5, 6));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
